// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : mem_copy_engine
//  Purpose  : Copies len words from src_addr.. to dst_addr.. of a single-port
//             RAM with registered (1-cycle) read data. Each word takes one read
//             cycle and one write cycle. Copying is strictly ascending, so
//             overlapping ranges give forward-copy semantics.
//  Ports    : clk, rst_n           - clock, asynchronous active-low reset
//             start                - copy request (only honoured in IDLE)
//             src_addr, dst_addr   - first source / destination word address
//             len                  - number of words (0 = no RAM access)
//             busy, done           - copy in progress / 1-cycle completion
//             mem_en, mem_write    - RAM enable and write strobe
//             mem_addr             - RAM address
//             mem_write_data       - RAM write data
//             mem_read_data        - RAM registered read data
//  Revision : 1.0 - initial release
// ============================================================================
module mem_copy_engine #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_write_data,
  input  logic [WIDTH-1:0]  mem_read_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [LEN_W:0]    w_idx_inc;
  logic [ADDR_W-1:0] w_idx_ext;
  logic              w_accept;

  // One extra bit so idx+1 never overflows, even for len = 2^LEN_W-1.
  assign w_idx_inc = {1'b0, r_idx} + {{LEN_W{1'b0}}, 1'b1};
  assign w_idx_ext = ADDR_W'(r_idx);
  assign w_accept  = (r_state == IDLE) && start && (len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_src <= src_addr;
        r_dst <= dst_addr;
        r_len <= len;
        r_idx <= '0;
      end else if (r_state == WR) begin
        r_idx <= w_idx_inc[LEN_W-1:0];
      end
    end
  end

  // Outputs decode from the state register only, so an asynchronous reset
  // drives every output to 0 without waiting for a clock edge.
  always_comb begin
    w_state_next   = r_state;
    busy           = 1'b0;
    done           = 1'b0;
    mem_en         = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (len == '0) ? DONE : RD;
        end
      end
      RD: begin
        busy         = 1'b1;
        mem_en       = 1'b1;
        mem_addr     = r_src + w_idx_ext;
        w_state_next = WR;
      end
      WR: begin
        // Read data from the previous RD edge is presented this cycle.
        busy           = 1'b1;
        mem_en         = 1'b1;
        mem_write      = 1'b1;
        mem_addr       = r_dst + w_idx_ext;
        mem_write_data = mem_read_data;
        w_state_next   = (w_idx_inc < {1'b0, r_len}) ? RD : DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_copy_engine
//  Purpose  : Self-checking bench for mem_copy_engine with a 1-cycle-latency
//             RAM model and a forward-copy reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [7:0]  len = '0;
  logic        busy, done, mem_en, mem_write;
  logic [15:0] mem_addr;
  logic [7:0]  mem_write_data;
  logic [7:0]  mem_read_data;

  // RAM model side controls (bench use only, while the engine is idle)
  logic        ram_clear = 1'b0;
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;

  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  // Expected access trace: {write, addr} and write data.
  logic [16:0] exp_acc[$];
  logic [7:0]  exp_dat[$];

  always #5 clk = ~clk;

  mem_copy_engine #(.WIDTH(8), .ADDR_W(16), .LEN_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .len            (len),
    .busy           (busy),
    .done           (done),
    .mem_en         (mem_en),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 65536; i++) ram[i] <= '0;
    end else if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end else if (mem_en) begin
      if (mem_write) ram[mem_addr] <= mem_write_data;
      else           mem_read_data <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: forward element-by-element copy with 16-bit address wrap.
  task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
    logic [15:0] a, b;
    logic [7:0]  v;
    exp_acc.delete();
    exp_dat.delete();
    for (int i = 0; i < n; i++) begin
      a = s + 16'(i);
      b = d + 16'(i);
      v = ref_mem[a];
      ref_mem[b] = v;
      exp_acc.push_back({1'b0, a}); exp_dat.push_back(8'h00);
      exp_acc.push_back({1'b1, b}); exp_dat.push_back(v);
    end
  endtask

  function automatic int mem_diff();
    int c = 0;
    for (int i = 0; i < 65536; i++) if (ram[i] !== ref_mem[i]) c++;
    return c;
  endfunction

  task automatic clear_mem();
    ram_clear = 1'b1;
    @(posedge clk); #1;
    ram_clear = 1'b0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
  endtask

  task automatic load(input logic [15:0] a, input logic [7:0] v);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    @(posedge clk); #1;
    ld_en = 1'b0;
    ref_mem[a] = v;
  endtask

  // Runs one copy and checks timing, the full access trace and memory.
  // poke: re-assert start with different parameters during the copy.
  task automatic run_copy(input string tag, input logic [15:0] s, input logic [15:0] d,
                          input logic [7:0] n, input bit poke);
    int nn = int'(n);
    int busy_cnt = 0, done_cnt = 0, done_at = -1;
    logic [16:0] act_acc[$];
    logic [7:0]  act_dat[$];
    model_copy(s, d, nn);
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 2 * nn + 3; k++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = k; end
      if (mem_en) begin
        act_acc.push_back({mem_write, mem_addr});
        act_dat.push_back(mem_write_data);
      end
      if (poke && k == 3) begin
        start = 1'b1; len = n + 8'd5; src_addr = s ^ 16'h5555; dst_addr = d ^ 16'h0F0F;
      end
      if (poke && k == 4) start = 1'b0;
      @(posedge clk); #1;
    end
    check({tag, "_busy_cycles"}, busy_cnt, 2 * nn);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_at, 2 * nn + 1);
    check({tag, "_access_count"}, act_acc.size(), exp_acc.size());
    if (act_acc.size() == exp_acc.size()) begin
      for (int j = 0; j < exp_acc.size(); j++) begin
        check({tag, "_access"}, act_acc[j], exp_acc[j]);
        if (exp_acc[j][16]) check({tag, "_wdata"}, act_dat[j], exp_dat[j]);
      end
    end
    check({tag, "_mem_diff"}, mem_diff(), 0);
  endtask

  initial begin
    logic [15:0] s, d;
    logic [7:0]  n;
    bit          seen;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mem();

    // Basic 4-word copy
    load(16'h0000, 8'h11); load(16'h0001, 8'h22);
    load(16'h0002, 8'h33); load(16'h0003, 8'h44);
    run_copy("basic", 16'h0000, 16'h0008, 8'd4, 1'b0);
    check("basic_ram8", ram[8], 8'h11);
    check("basic_ram11", ram[11], 8'h44);

    // Zero length: done next cycle, no RAM access
    run_copy("len0", 16'h0030, 16'h0040, 8'd0, 1'b0);

    // Address wrap
    load(16'hFFFE, 8'hA1); load(16'hFFFF, 8'hA2); load(16'h0000, 8'hA3);
    run_copy("wrap", 16'hFFFE, 16'h0004, 8'd3, 1'b0);

    // Overlapping forward copy
    load(16'h0000, 8'hAA);
    run_copy("overlap", 16'h0000, 16'h0001, 8'd3, 1'b0);
    check("overlap_ram3", ram[3], 8'hAA);

    // Start during the copy is ignored
    for (int i = 0; i < 4; i++) load(16'h0100 + 16'(i), 8'($urandom));
    run_copy("poke", 16'h0100, 16'h0200, 8'd4, 1'b1);

    // Maximum length
    for (int i = 0; i < 255; i++) load(16'h1000 + 16'(i), 8'($urandom));
    run_copy("max", 16'h1000, 16'h2000, 8'd255, 1'b0);

    // Start in DONE ignored, start in the following IDLE accepted
    load(16'h0300, 8'h5A); load(16'h0301, 8'hC3); load(16'h0400, 8'h7E);
    model_copy(16'h0300, 16'h0380, 2);
    start = 1'b1; src_addr = 16'h0300; dst_addr = 16'h0380; len = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("chain_done", done, 1);
    start = 1'b1; src_addr = 16'h0400; dst_addr = 16'h0480; len = 8'd1;
    @(posedge clk); #1;
    check("chain_ignored_busy", busy, 0);
    check("chain_ignored_done", done, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("chain_accepted_busy", busy, 1);
    check("chain_accepted_addr", mem_addr, 16'h0400);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("chain2_done", done, 1);
    model_copy(16'h0400, 16'h0480, 1);
    check("chain_mem_diff", mem_diff(), 0);

    // Reset mid-copy after the second write
    for (int i = 0; i < 4; i++) load(16'h0600 + 16'(i), 8'($urandom_range(1, 255)));
    model_copy(16'h0600, 16'h0700, 2);
    start = 1'b1; src_addr = 16'h0600; dst_addr = 16'h0700; len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_mem_en", mem_en, 0);
    check("abort_mem_write", mem_write, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_wdata", mem_write_data, 0);
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (done) seen = 1'b1;
    check("abort_idle_busy", busy, 0);
    check("abort_idle_mem_en", mem_en, 0);
    check("abort_no_done", seen, 0);
    check("abort_mem_diff", mem_diff(), 0);

    // Randomized copies, some overlapping, some wrapping
    for (int t = 0; t < 10; t++) begin
      n = 8'($urandom_range(1, 16));
      s = 16'($urandom);
      d = ($urandom_range(0, 1) == 1) ? s + 16'($urandom_range(0, 20)) : 16'($urandom);
      for (int i = 0; i < int'(n); i++) load(s + 16'(i), 8'($urandom));
      run_copy("rand", s, d, n, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
